// File: rtl/writeback_rob_pkg.sv
// writeback_rob_pkg
//   Constants and types shared by the in-order writeback buffer and the
//   dual-write-port register file it feeds.
//   - DW / RW / NUM_REGS : register-file data width, register-number width,
//                          number of architectural registers
//   - ROB_DEPTH / ROB_TAGW : default buffer depth and tag width
//   - rob_entry_t        : one buffer entry {valid, done, wen, dest, data}
//   - entry_ready()      : an entry may retire (allocated and completed)
package writeback_rob_pkg;

  localparam int DW        = 16;
  localparam int RW        = 3;
  localparam int NUM_REGS  = 1 << RW;
  localparam int ROB_DEPTH = 4;
  localparam int ROB_TAGW  = 2;

  typedef struct packed {
    logic          valid;
    logic          done;
    logic          wen;
    logic [RW-1:0] dest;
    logic [DW-1:0] data;
  } rob_entry_t;

  function automatic logic entry_ready(input rob_entry_t e);
    return e.valid && e.done;
  endfunction

endpackage

// File: rtl/writeback_rob_retire_sel.sv
// writeback_rob_retire_sel
//   Combinational two-slot head selector. Slot 0 is the oldest entry, slot 1
//   the next one. Slot 1 may only retire together with slot 0 so retirement
//   stays strictly in program order.
//   Ports:
//   - slot0_entry, slot1_entry : entries at head and head+1
//   - hold                     : suppress all retirement (reset or flush)
//   - write0/1, num_write0/1_out, data_write0/1_out : register-file drives
//   - retire_cnt               : number of entries leaving this cycle (0..2)
module writeback_rob_retire_sel
  import writeback_rob_pkg::*;
(
  input  rob_entry_t    slot0_entry,
  input  rob_entry_t    slot1_entry,
  input  logic          hold,
  output logic          write0,
  output logic [RW-1:0] num_write0_out,
  output logic [DW-1:0] data_write0_out,
  output logic          write1,
  output logic [RW-1:0] num_write1_out,
  output logic [DW-1:0] data_write1_out,
  output logic [1:0]    retire_cnt
);

  // Slot selection and write-port drive; an entry with wen=0 still uses its slot.
  always_comb begin
    write0          = 1'b0;
    num_write0_out  = {RW{1'b0}};
    data_write0_out = {DW{1'b0}};
    write1          = 1'b0;
    num_write1_out  = {RW{1'b0}};
    data_write1_out = {DW{1'b0}};
    retire_cnt      = 2'd0;
    if (!hold && entry_ready(slot0_entry)) begin
      write0          = slot0_entry.wen;
      num_write0_out  = slot0_entry.dest;
      data_write0_out = slot0_entry.data;
      if (entry_ready(slot1_entry)) begin
        write1          = slot1_entry.wen;
        num_write1_out  = slot1_entry.dest;
        data_write1_out = slot1_entry.data;
        retire_cnt      = 2'd2;
      end else begin
        retire_cnt      = 2'd1;
      end
    end else begin
      retire_cnt = 2'd0;
    end
  end

endmodule

// File: rtl/writeback_rob.sv
// writeback_rob
//   In-order writeback buffer in front of the dual-write-port register file.
//   Issue allocates entries in program order at the tail; execution units
//   complete them out of order by tag; up to two completed entries at the head
//   drain per cycle onto register-file write ports 0 and 1.
//   Ports:
//   - clk, rst (synchronous, active-low), flush (discard everything)
//   - alloc_valid/alloc_wen/alloc_dest in, alloc_ready/alloc_tag out
//   - cpl0_* / cpl1_* : completion ports (port 0 wins on a tag collision)
//   - write0/1, num_write0/1_out, data_write0/1_out : register-file writes
//   - count, empty : occupancy
module writeback_rob
  import writeback_rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAGW  = ROB_TAGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc_valid,
  input  logic            alloc_wen,
  input  logic [RW-1:0]   alloc_dest,
  output logic            alloc_ready,
  output logic [TAGW-1:0] alloc_tag,
  input  logic            cpl0_valid,
  input  logic [TAGW-1:0] cpl0_tag,
  input  logic [DW-1:0]   cpl0_data,
  input  logic            cpl1_valid,
  input  logic [TAGW-1:0] cpl1_tag,
  input  logic [DW-1:0]   cpl1_data,
  output logic            write0,
  output logic [RW-1:0]   num_write0_out,
  output logic [DW-1:0]   data_write0_out,
  output logic            write1,
  output logic [RW-1:0]   num_write1_out,
  output logic [DW-1:0]   data_write1_out,
  output logic [TAGW:0]   count,
  output logic            empty
);

  localparam logic [TAGW:0] FULL_COUNT = (TAGW+1)'(DEPTH);

  rob_entry_t      entries_q [DEPTH];
  rob_entry_t      entries_d [DEPTH];
  logic [TAGW-1:0] head_q, head_d;
  logic [TAGW-1:0] tail_q, tail_d;
  logic [TAGW:0]   count_q, count_d;

  logic [TAGW-1:0] head_p1;
  logic            hold;
  logic            alloc_fire;
  logic            cpl0_hit;
  logic            cpl1_hit;
  logic [1:0]      retire_cnt;

  assign head_p1     = head_q + TAGW'(1);
  // No same-cycle bypass from retirement: readiness is registered state only.
  assign alloc_ready = (count_q != FULL_COUNT);
  assign alloc_tag   = tail_q;
  assign count       = count_q;
  assign empty       = (count_q == (TAGW+1)'(0));
  // Reset or flush must not let a partial write escape to the register file.
  assign hold        = flush || !rst;
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;

  writeback_rob_retire_sel u_retire_sel (
    .slot0_entry     (entries_q[head_q]),
    .slot1_entry     (entries_q[head_p1]),
    .hold            (hold),
    .write0          (write0),
    .num_write0_out  (num_write0_out),
    .data_write0_out (data_write0_out),
    .write1          (write1),
    .num_write1_out  (num_write1_out),
    .data_write1_out (data_write1_out),
    .retire_cnt      (retire_cnt)
  );

  // Completion acceptance: only allocated, not-yet-done entries take data.
  // The entry at tail is never valid while allocation is possible, so a
  // completion aimed at the tag being allocated this cycle is dropped.
  always_comb begin
    cpl0_hit = cpl0_valid && !flush
               && entries_q[cpl0_tag].valid && !entries_q[cpl0_tag].done;
    cpl1_hit = cpl1_valid && !flush
               && entries_q[cpl1_tag].valid && !entries_q[cpl1_tag].done
               && !(cpl0_valid && (cpl0_tag == cpl1_tag));
  end

  // Next-state: retire at head, allocate at tail, record completions, or flush.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
      head_d  = {TAGW{1'b0}};
      tail_d  = {TAGW{1'b0}};
      count_d = {(TAGW+1){1'b0}};
    end else begin
      if (retire_cnt != 2'd0) begin
        entries_d[head_q].valid = 1'b0;
        entries_d[head_q].done  = 1'b0;
      end else begin
        entries_d[head_q].valid = entries_q[head_q].valid;
      end
      if (retire_cnt == 2'd2) begin
        entries_d[head_p1].valid = 1'b0;
        entries_d[head_p1].done  = 1'b0;
      end else begin
        entries_d[head_p1].valid = entries_d[head_p1].valid;
      end
      // Tail never aliases a retiring entry: retiring needs count>0, and
      // allocating with tail==head needs count==0.
      if (alloc_fire) begin
        entries_d[tail_q].valid = 1'b1;
        entries_d[tail_q].done  = 1'b0;
        entries_d[tail_q].wen   = alloc_wen;
        entries_d[tail_q].dest  = alloc_dest;
        tail_d                  = tail_q + TAGW'(1);
      end else begin
        tail_d = tail_q;
      end
      // Completions never target a retiring entry (those are already done).
      if (cpl0_hit) begin
        entries_d[cpl0_tag].done = 1'b1;
        entries_d[cpl0_tag].data = cpl0_data;
      end else begin
        entries_d[cpl0_tag].done = entries_d[cpl0_tag].done;
      end
      if (cpl1_hit) begin
        entries_d[cpl1_tag].done = 1'b1;
        entries_d[cpl1_tag].data = cpl1_data;
      end else begin
        entries_d[cpl1_tag].done = entries_d[cpl1_tag].done;
      end
      head_d  = head_q + TAGW'(retire_cnt);
      count_d = count_q + (TAGW+1)'(alloc_fire) - (TAGW+1)'(retire_cnt);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= {TAGW{1'b0}};
      tail_q  <= {TAGW{1'b0}};
      count_q <= {(TAGW+1){1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_writeback_rob.sv
// tb_writeback_rob
//   Scenario tasks drive the buffer; expected register-file writes are queued
//   in program order as completions are driven and popped by a monitor when
//   the write ports fire. A shadow register file applies port 1 after port 0.
module tb_writeback_rob;
  import writeback_rob_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          alloc_valid;
  logic          alloc_wen;
  logic [RW-1:0] alloc_dest;
  logic          alloc_ready;
  logic [1:0]    alloc_tag;
  logic          cpl0_valid, cpl1_valid;
  logic [1:0]    cpl0_tag, cpl1_tag;
  logic [DW-1:0] cpl0_data, cpl1_data;
  logic          write0, write1;
  logic [RW-1:0] num_write0_out, num_write1_out;
  logic [DW-1:0] data_write0_out, data_write1_out;
  logic [2:0]    count;
  logic          empty;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [RW-1:0] num;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  logic [DW-1:0] rf [NUM_REGS];

  writeback_rob dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_wen(alloc_wen), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cpl0_valid(cpl0_valid), .cpl0_tag(cpl0_tag), .cpl0_data(cpl0_data),
    .cpl1_valid(cpl1_valid), .cpl1_tag(cpl1_tag), .cpl1_data(cpl1_data),
    .write0(write0), .num_write0_out(num_write0_out), .data_write0_out(data_write0_out),
    .write1(write1), .num_write1_out(num_write1_out), .data_write1_out(data_write1_out),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Shadow register file: port 1 written after port 0, so it wins.
  always @(posedge clk) begin
    if (write0) rf[num_write0_out] <= data_write0_out;
    if (write1) rf[num_write1_out] <= data_write1_out;
  end

  // Scoreboard monitor: every register-file write must match the next expected one.
  always @(negedge clk) begin
    wr_t e;
    if (write0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_port0 unexpected write num=%0d data=%h", num_write0_out, data_write0_out);
      end else begin
        e = exp_q.pop_front();
        if ({num_write0_out, data_write0_out} !== {e.num, e.data}) begin
          errors++;
          $display("FAIL sb_port0 got num=%0d data=%h exp num=%0d data=%h",
                   num_write0_out, data_write0_out, e.num, e.data);
        end
      end
    end
    if (write1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_port1 unexpected write num=%0d data=%h", num_write1_out, data_write1_out);
      end else begin
        e = exp_q.pop_front();
        if ({num_write1_out, data_write1_out} !== {e.num, e.data}) begin
          errors++;
          $display("FAIL sb_port1 got num=%0d data=%h exp num=%0d data=%h",
                   num_write1_out, data_write1_out, e.num, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; alloc_valid = 1'b0; alloc_wen = 1'b0; alloc_dest = '0;
    cpl0_valid = 1'b0; cpl0_tag = '0; cpl0_data = '0;
    cpl1_valid = 1'b0; cpl1_tag = '0; cpl1_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic push_exp(input logic [RW-1:0] num, input logic [DW-1:0] data);
    wr_t e;
    e.num = num; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0; alloc_valid = 1'b1; alloc_wen = 1'b1; alloc_dest = 3'd1;
    step();
    @(negedge clk);
    checks++;
    if ({write0, write1} !== 2'b00) begin
      errors++; $display("FAIL reset_writes got %b exp 00", {write0, write1});
    end
    step();
    rst = 1'b1; alloc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({count, empty, alloc_ready, write0, write1, alloc_tag} !== {3'd0, 1'b1, 1'b1, 2'b00, 2'd0}) begin
      errors++;
      $display("FAIL reset_state got count=%0d empty=%b ready=%b w=%b%b tag=%0d exp 0 1 1 00 0",
               count, empty, alloc_ready, write0, write1, alloc_tag);
    end
    step();
  endtask

  task automatic test_out_of_order();
    do_reset();
    alloc_valid = 1'b1; alloc_wen = 1'b1; alloc_dest = 3'd3;
    @(negedge clk);
    checks++;
    if (alloc_tag !== 2'd0) begin errors++; $display("FAIL ooo_tag0 got %0d exp 0", alloc_tag); end
    step();
    alloc_dest = 3'd5;
    @(negedge clk);
    checks++;
    if (alloc_tag !== 2'd1) begin errors++; $display("FAIL ooo_tag1 got %0d exp 1", alloc_tag); end
    step();
    alloc_valid = 1'b0;
    push_exp(3'd3, 16'h1234);
    push_exp(3'd5, 16'hBEEF);
    cpl0_valid = 1'b1; cpl0_tag = 2'd1; cpl0_data = 16'hBEEF;
    step();
    cpl0_tag = 2'd0; cpl0_data = 16'h1234;
    @(negedge clk);
    checks++;
    if ({write0, write1} !== 2'b00) begin
      errors++; $display("FAIL ooo_hold got %b exp 00 (older entry not done)", {write0, write1});
    end
    step();
    cpl0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({write0, num_write0_out, data_write0_out, write1, num_write1_out, data_write1_out}
        !== {1'b1, 3'd3, 16'h1234, 1'b1, 3'd5, 16'hBEEF}) begin
      errors++;
      $display("FAIL ooo_drain got w0=%b n0=%0d d0=%h w1=%b n1=%0d d1=%h exp 1 3 1234 1 5 beef",
               write0, num_write0_out, data_write0_out, write1, num_write1_out, data_write1_out);
    end
    step();
    checks++;
    if ({rf[3], rf[5], count} !== {16'h1234, 16'hBEEF, 3'd0}) begin
      errors++;
      $display("FAIL ooo_rf got R3=%h R5=%h count=%0d exp 1234 beef 0", rf[3], rf[5], count);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1; alloc_wen = 1'b1; alloc_dest = RW'(i + 1);
      @(negedge clk);
      checks++;
      if (alloc_tag !== 2'(i)) begin errors++; $display("FAIL full_tag got %0d exp %0d", alloc_tag, i); end
      step();
    end
    // Hold a 5th request while completing the two oldest entries.
    alloc_dest = 3'd7;
    push_exp(3'd1, 16'h1111);
    push_exp(3'd2, 16'h2222);
    cpl0_valid = 1'b1; cpl0_tag = 2'd0; cpl0_data = 16'h1111;
    cpl1_valid = 1'b1; cpl1_tag = 2'd1; cpl1_data = 16'h2222;
    @(negedge clk);
    checks++;
    if ({alloc_ready, count, write0} !== {1'b0, 3'd4, 1'b0}) begin
      errors++; $display("FAIL full_state got ready=%b count=%0d w0=%b exp 0 4 0", alloc_ready, count, write0);
    end
    step();
    cpl0_valid = 1'b0; cpl1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({write0, write1, alloc_ready, count} !== {2'b11, 1'b0, 3'd4}) begin
      errors++;
      $display("FAIL full_retire got w=%b%b ready=%b count=%0d exp 11 0 4", write0, write1, alloc_ready, count);
    end
    step();
    @(negedge clk);
    checks++;
    if ({count, alloc_ready, alloc_tag} !== {3'd2, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL full_after got count=%0d ready=%b tag=%0d exp 2 1 0", count, alloc_ready, alloc_tag);
    end
    step();
    alloc_dest = 3'd6;
    @(negedge clk);
    checks++;
    if ({alloc_tag, count} !== {2'd1, 3'd3}) begin
      errors++; $display("FAIL full_wrap got tag=%0d count=%0d exp 1 3", alloc_tag, count);
    end
    step();
    alloc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 3'd4) begin errors++; $display("FAIL full_refill got count=%0d exp 4", count); end
  endtask

  task automatic test_same_dest();
    do_reset();
    alloc_valid = 1'b1; alloc_wen = 1'b1; alloc_dest = 3'd2;
    step();
    step();
    alloc_valid = 1'b0;
    push_exp(3'd2, 16'h00AA);
    push_exp(3'd2, 16'h00BB);
    cpl0_valid = 1'b1; cpl0_tag = 2'd1; cpl0_data = 16'h00BB;
    cpl1_valid = 1'b1; cpl1_tag = 2'd0; cpl1_data = 16'h00AA;
    step();
    cpl0_valid = 1'b0; cpl1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({write0, write1, num_write0_out, num_write1_out} !== {2'b11, 3'd2, 3'd2}) begin
      errors++;
      $display("FAIL same_dest_ports got w=%b%b n0=%0d n1=%0d exp 11 2 2",
               write0, write1, num_write0_out, num_write1_out);
    end
    step();
    checks++;
    if (rf[2] !== 16'h00BB) begin errors++; $display("FAIL same_dest_rf got R2=%h exp 00bb", rf[2]); end
  endtask

  task automatic test_wen0();
    do_reset();
    alloc_valid = 1'b1; alloc_wen = 1'b0; alloc_dest = 3'd6;
    step();
    alloc_wen = 1'b1; alloc_dest = 3'd4;
    step();
    alloc_valid = 1'b0;
    push_exp(3'd4, 16'h4444);
    cpl0_valid = 1'b1; cpl0_tag = 2'd0; cpl0_data = 16'h6666;
    cpl1_valid = 1'b1; cpl1_tag = 2'd1; cpl1_data = 16'h4444;
    step();
    cpl0_valid = 1'b0; cpl1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({write0, write1, num_write1_out} !== {1'b0, 1'b1, 3'd4}) begin
      errors++;
      $display("FAIL wen0_ports got w=%b%b n1=%0d exp 01 4", write0, write1, num_write1_out);
    end
    step();
    @(negedge clk);
    checks++;
    if ({count, alloc_tag} !== {3'd0, 2'd2}) begin
      errors++; $display("FAIL wen0_head got count=%0d tag=%0d exp 0 2", count, alloc_tag);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_wen = 1'b1; alloc_dest = RW'(i + 1);
      step();
    end
    alloc_valid = 1'b0;
    cpl0_valid = 1'b1; cpl0_tag = 2'd0; cpl0_data = 16'hA0A0;
    cpl1_valid = 1'b1; cpl1_tag = 2'd1; cpl1_data = 16'hA1A1;
    step();
    cpl0_valid = 1'b0; cpl1_valid = 1'b0;
    // Entries 0,1 would retire now; flush also carries an allocation and a completion.
    flush = 1'b1; alloc_valid = 1'b1; alloc_dest = 3'd7;
    cpl0_valid = 1'b1; cpl0_tag = 2'd2; cpl0_data = 16'hA2A2;
    @(negedge clk);
    checks++;
    if ({write0, write1} !== 2'b00) begin
      errors++; $display("FAIL flush_writes got %b exp 00", {write0, write1});
    end
    step();
    flush = 1'b0; alloc_valid = 1'b0; cpl0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({count, alloc_tag, empty} !== {3'd0, 2'd0, 1'b1}) begin
      errors++; $display("FAIL flush_state got count=%0d tag=%0d empty=%b exp 0 0 1", count, alloc_tag, empty);
    end
    cpl0_valid = 1'b1; cpl0_tag = 2'd0; cpl0_data = 16'h5555;
    step();
    cpl0_valid = 1'b0;
    alloc_valid = 1'b1; alloc_dest = 3'd1;
    step();
    alloc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({count, write0} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL flush_stale_cpl got count=%0d w0=%b exp 1 0", count, write0);
    end
    step();
  endtask

  initial begin
    for (int r = 0; r < NUM_REGS; r++) rf[r] = '0;
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_out_of_order();
    test_full();
    test_same_dest();
    test_wen0();
    test_flush();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d pending writes exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_rob.md
Name: writeback_rob

Overview:
- In-order writeback/retire buffer that sits directly upstream of the dual-write-port register file.
- Issue allocates an entry per instruction in program order.
- Execution units complete entries out of order, using a tag.
- The block drains up to two completed entries per cycle, oldest first, onto register-file write ports 0 and 1.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2
DW, 16, data width
RW, 3, register-number width
TAGW, 2, entry-tag width; equals log2(DEPTH)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-low
flush  in  1  discard all entries
alloc_valid  in  1  issue requests an entry
alloc_wen  in  1  instruction writes a register
alloc_dest  in  RW  destination register number
alloc_ready  out  1  an entry is free
alloc_tag  out  TAGW  tag given to this cycle's allocation (equals tail)
cpl0_valid, cpl1_valid  in  1  completion ports 0 and 1
cpl0_tag, cpl1_tag  in  TAGW  entry being completed
cpl0_data, cpl1_data  in  DW  result data
write0, write1  out  1  register-file write enables
num_write0_out, num_write1_out  out  RW  register-file write numbers
data_write0_out, data_write1_out  out  DW  register-file write data
count  out  TAGW+1  number of occupied entries
empty  out  1  count == 0

Behaviour:
- State:
  - circular array of {valid, done, wen, dest, data};
  - head and tail pointers of TAGW bits, wrapping modulo DEPTH;
  - count register.
- Reset, rst=0 at posedge:
  - all valid/done bits, head, tail and count are cleared.
  - Consequently write0=write1=0, alloc_ready=1, alloc_tag=0, count=0, empty=1.
- Priority: rst > flush > normal operation.
- Allocation:
  - alloc_ready = (count != DEPTH); it depends on registered state only.
  - There is no same-cycle bypass from retirement, so a full buffer refuses allocation even while retiring.
  - On alloc_valid && alloc_ready, at the edge: entry[tail] becomes {valid=1, done=0, wen, dest}, and tail increments.
  - alloc_valid while alloc_ready=0 is dropped; issue must hold the request.
- Completion:
  - On cplN_valid, if entry[cplN_tag] is valid and not done: data is stored and done set at the edge.
  - Completions to an invalid or already-done entry are ignored.
  - This includes a completion to the tag being allocated in the same cycle.
  - If both ports target the same tag, port 0 wins.
- Retirement (combinational from registered state; zero added latency):
  - Slot 0 = entry[head]; it retires if valid && done.
  - Slot 1 = entry[head+1]; it retires only if slot 0 retires and entry[head+1] is valid && done.
  - A retiring slot drives writeN = wen, num_writeN_out = dest, data_writeN_out = data.
  - An entry with wen=0 still consumes its slot, with writeN=0.
  - Non-retiring slots drive writeN=0.
  - At the edge, retired entries are invalidated and head advances by 0, 1 or 2.
- Latency: a completion accepted at edge N is written into the register file at edge N+1, provided every older entry is already done.
- Same destination on both slots:
  - Both writes are driven.
  - The register file applies port 1 after port 0, so the younger result (slot 1) wins.
  - This is required behaviour.
- count update: count_next = count + (alloc accepted) - (number retired). Simultaneous allocation and retirement are legal.
- Flush:
  - While flush=1, write0=write1=0, and allocation and completion are ignored.
  - At the edge, the buffer clears exactly as in reset.
- Reset or flush mid-operation: no partial write reaches the register file in that cycle.

Decomposition:
- Shared package holds:
  - DW, RW and the register-count constants shared with the register file;
  - a packed struct rob_entry_t {valid, done, wen, dest, data}.
- Natural sub-module: writeback_rob_retire_sel, the combinational two-slot head selector producing retire count and write-port drives.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with alloc_valid=1 -> after release, count=0, empty=1, alloc_ready=1, write0=write1=0.
2. Out-of-order completion:
   - Stimulus: allocate tags 0,1 (dest 3,5); complete tag1=0xBEEF, then next cycle complete tag0=0x1234.
   - Response: the cycle after the tag0 completion shows write0=1, num=3, data 0x1234 and write1=1, num=5, data 0xBEEF; R3=0x1234 and R5=0xBEEF afterwards.
3. Full boundary:
   - Stimulus: allocate 4 entries with none completed.
   - Response: alloc_ready=0 and count=4; a 5th request is dropped. After completing tags 0 and 1 in one cycle, both retire next cycle, count=2 and alloc_ready=1.
   - Pointer wrap: new tags 0 and 1 are reissued.
4. Same destination:
   - Stimulus: two entries, both dest 2, completed with 0x00AA (older) and 0x00BB (younger).
   - Response: both write ports fire in the same cycle; R2=0x00BB.
5. wen=0 entry:
   - Stimulus: entry 0 has wen=0, entry 1 has dest 4; complete both.
   - Response: write0=0, write1=1, num=4; head advances by 2.
6. Flush:
   - Stimulus: assert flush with 3 entries, 2 of them completed.
   - Response: no write that cycle; next cycle count=0 and alloc_tag=0; a later completion to an old tag is ignored.
